parking_meter_countdown: RTL and testbench



---
 rtl/parking_pkg.sv | 31 +++
 rtl/coin_value_lut.sv | 32 +++
 rtl/parking_meter_countdown.sv | 170 +++++++++++++++++
 tb/tb_parking_meter_countdown.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// ============================================================================
// parking_pkg
// Shared definitions for the parking-meter pay side: the state code seen by
// the display driver, the default coin denominations and the display-limited
// credit ceiling.
// ============================================================================
package parking_pkg;

    // Counter width and 4-digit display ceiling.
    localparam int W         = 14;
    localparam int MAX_SEC   = 9999;

    // Default seconds credited per coin denomination index.
    localparam int COIN0_SEC = 60;
    localparam int COIN1_SEC = 120;
    localparam int COIN2_SEC = 180;
    localparam int COIN3_SEC = 300;

    // Free time for a car that parks with no credit, and low-credit threshold.
    localparam int GRACE_SEC = 10;
    localparam int WARN_SEC  = 30;

    // State code; the display driver decodes this to pick blink / "EXP" text.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRACE   = 2'd1,
        ST_RUN     = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

endpackage

// File: rtl/coin_value_lut.sv
// ============================================================================
// coin_value_lut
// Combinational map from coin denomination index to credited seconds.
// Also used by the coin-total audit counter.
//
// Ports:
//   coin_val  in  2  denomination index
//   coin_sec  out W  seconds credited for that denomination
// ============================================================================
module coin_value_lut
    import parking_pkg::*;
#(
    parameter int W         = parking_pkg::W,
    parameter int COIN0_SEC = parking_pkg::COIN0_SEC,
    parameter int COIN1_SEC = parking_pkg::COIN1_SEC,
    parameter int COIN2_SEC = parking_pkg::COIN2_SEC,
    parameter int COIN3_SEC = parking_pkg::COIN3_SEC
) (
    input  logic [1:0]   coin_val,
    output logic [W-1:0] coin_sec
);

    always_comb begin
        case (coin_val)
            2'd0:    coin_sec = W'(COIN0_SEC);
            2'd1:    coin_sec = W'(COIN1_SEC);
            2'd2:    coin_sec = W'(COIN2_SEC);
            default: coin_sec = W'(COIN3_SEC);
        endcase
    end

endmodule

// File: rtl/parking_meter_countdown.sv
// ============================================================================
// parking_meter_countdown
// Pay-side timer: turns coin insertions into prepaid seconds, counts them
// down while a car is parked and flags expiry.
//
// Ports:
//   clk           in  1  system clock
//   rst           in  1  synchronous active-high reset
//   sec_tick      in  1  one-cycle pulse per second
//   parked        in  1  car present in bay (level)
//   coin_in       in  1  one-cycle pulse, coin accepted
//   coin_val      in  2  denomination index, valid with coin_in
//   time_left     out W  remaining prepaid seconds
//   state         out 2  IDLE=0, GRACE=1, RUN=2, EXPIRED=3
//   low_warn      out 1  RUN with 0 < time_left <= WARN_SEC
//   expired       out 1  high while EXPIRED
//   expire_pulse  out 1  first cycle of EXPIRED
//   blink         out 1  toggles per sec_tick while EXPIRED
// ============================================================================
module parking_meter_countdown
    import parking_pkg::*;
#(
    parameter int W         = parking_pkg::W,
    parameter int MAX_SEC   = parking_pkg::MAX_SEC,
    parameter int COIN0_SEC = parking_pkg::COIN0_SEC,
    parameter int COIN1_SEC = parking_pkg::COIN1_SEC,
    parameter int COIN2_SEC = parking_pkg::COIN2_SEC,
    parameter int COIN3_SEC = parking_pkg::COIN3_SEC,
    parameter int GRACE_SEC = parking_pkg::GRACE_SEC,
    parameter int WARN_SEC  = parking_pkg::WARN_SEC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sec_tick,
    input  logic         parked,
    input  logic         coin_in,
    input  logic [1:0]   coin_val,
    output logic [W-1:0] time_left,
    output logic [1:0]   state,
    output logic         low_warn,
    output logic         expired,
    output logic         expire_pulse,
    output logic         blink
);

    state_t       state_r, state_n;
    logic [W-1:0] grace_cnt, grace_n;
    logic [W-1:0] time_n;
    logic         blink_n;

    logic [W-1:0] coin_sec;
    logic [W-1:0] add;
    logic [W:0]   sum_wide;
    logic [W-1:0] sum;
    logic [W-1:0] run_next;

    coin_value_lut #(
        .W         (W),
        .COIN0_SEC (COIN0_SEC),
        .COIN1_SEC (COIN1_SEC),
        .COIN2_SEC (COIN2_SEC),
        .COIN3_SEC (COIN3_SEC)
    ) u_coin_lut (
        .coin_val (coin_val),
        .coin_sec (coin_sec)
    );

    // Credit arithmetic: one extra bit on the add so the saturation compare
    // sees the true sum.
    assign add      = coin_in ? coin_sec : '0;
    assign sum_wide = {1'b0, time_left} + {1'b0, add};
    assign sum      = (sum_wide > (W+1)'(MAX_SEC)) ? W'(MAX_SEC) : sum_wide[W-1:0];
    // Add-then-saturate-then-decrement; never wraps below zero.
    assign run_next = (sec_tick && sum != '0) ? sum - W'(1) : sum;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned; that is what keeps latches from inferring.
    always_comb begin
        state_n = state_r;
        time_n  = time_left;
        grace_n = grace_cnt;
        blink_n = blink;

        if (state_r != ST_IDLE && !parked) begin
            // Departure: credit is not carried over and any coin is discarded.
            state_n = ST_IDLE;
            time_n  = '0;
            grace_n = '0;
            blink_n = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    time_n = sum;  // prepay; ticks ignored here
                    if (parked) begin
                        if (sum != '0) begin
                            state_n = ST_RUN;
                        end else if (GRACE_SEC == 0) begin
                            state_n = ST_EXPIRED;
                        end else begin
                            state_n = ST_GRACE;
                            grace_n = W'(GRACE_SEC);
                        end
                    end
                end

                ST_GRACE: begin
                    if (coin_in) begin
                        // Coin beats a simultaneous tick: no decrement.
                        time_n  = sum;
                        grace_n = '0;
                        state_n = ST_RUN;
                    end else if (sec_tick) begin
                        if (grace_cnt <= W'(1)) begin
                            grace_n = '0;
                            state_n = ST_EXPIRED;
                        end else begin
                            grace_n = grace_cnt - W'(1);
                        end
                    end
                end

                ST_RUN: begin
                    time_n = run_next;
                    if (run_next == '0) begin
                        state_n = ST_EXPIRED;
                        blink_n = 1'b0;
                    end
                end

                default: begin  // ST_EXPIRED
                    time_n = '0;
                    if (coin_in) begin
                        // time_left is 0 here, so sum is just the coin value.
                        time_n  = sum;
                        blink_n = 1'b0;
                        if (sum != '0) state_n = ST_RUN;
                    end else if (sec_tick) begin
                        blink_n = ~blink;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, and the
    // reset is sampled on the clock edge (synchronous), overriding all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            time_left    <= '0;
            grace_cnt    <= '0;
            blink        <= 1'b0;
            low_warn     <= 1'b0;
            expired      <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            state_r      <= state_n;
            time_left    <= time_n;
            grace_cnt    <= grace_n;
            blink        <= blink_n;
            low_warn     <= (state_n == ST_RUN) && (time_n != '0) &&
                            (time_n <= W'(WARN_SEC));
            expired      <= (state_n == ST_EXPIRED);
            expire_pulse <= (state_n == ST_EXPIRED) && (state_r != ST_EXPIRED);
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_parking_meter_countdown.sv
// ============================================================================
// tb_parking_meter_countdown
// Directed-vector bench for parking_meter_countdown with hand-computed
// expected values.
// ============================================================================
module tb_parking_meter_countdown;

    localparam int W = 14;

    logic         clk;
    logic         rst;
    logic         sec_tick;
    logic         parked;
    logic         coin_in;
    logic [1:0]   coin_val;
    logic [W-1:0] time_left;
    logic [1:0]   state;
    logic         low_warn;
    logic         expired;
    logic         expire_pulse;
    logic         blink;

    int n_tests = 0;
    int n_fail  = 0;

    parking_meter_countdown dut (
        .clk          (clk),
        .rst          (rst),
        .sec_tick     (sec_tick),
        .parked       (parked),
        .coin_in      (coin_in),
        .coin_val     (coin_val),
        .time_left    (time_left),
        .state        (state),
        .low_warn     (low_warn),
        .expired      (expired),
        .expire_pulse (expire_pulse),
        .blink        (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock; inputs change and outputs are read 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] v);
        coin_in  = 1'b1;
        coin_val = v;
        cycle();
        coin_in  = 1'b0;
        coin_val = 2'd3;  // junk value while coin_in is low
    endtask

    task automatic ticks(input int n);
        sec_tick = 1'b1;
        repeat (n) cycle();
        sec_tick = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        sec_tick = 1'b0;
        parked   = 1'b1;
        coin_in  = 1'b1;
        coin_val = 2'd3;

        // Reset overrides parked and coin_in.
        cycle();
        cycle();
        check("rst_time", int'(time_left), 0);
        check("rst_state", int'(state), 0);
        check("rst_flags", int'({low_warn, expired, expire_pulse, blink}), 0);

        rst     = 1'b0;
        parked  = 1'b0;
        coin_in = 1'b0;
        cycle();

        // Prepay in IDLE: 120 + 300, tick ignored.
        coin(2'd1);
        coin(2'd3);
        check("prepay_time", int'(time_left), 420);
        ticks(1);
        check("idle_tick_ignored", int'(time_left), 420);
        check("idle_state", int'(state), 0);

        // Park with credit -> RUN, count down through the warning threshold.
        parked = 1'b1;
        cycle();
        check("run_entry_state", int'(state), 2);
        check("run_entry_time", int'(time_left), 420);
        ticks(389);
        check("time_31", int'(time_left), 31);
        check("low_warn_31", int'(low_warn), 0);
        ticks(1);
        check("time_30", int'(time_left), 30);
        check("low_warn_30", int'(low_warn), 1);
        ticks(29);
        check("time_1", int'(time_left), 1);
        check("low_warn_1", int'(low_warn), 1);
        ticks(1);
        check("expire_time", int'(time_left), 0);
        check("expire_state", int'(state), 3);
        check("expire_flag", int'(expired), 1);
        check("expire_pulse_on", int'(expire_pulse), 1);
        check("expire_low_warn", int'(low_warn), 0);
        cycle();
        check("expire_pulse_off", int'(expire_pulse), 0);
        check("expire_hold", int'(state), 3);

        // Leave, then park with zero credit -> GRACE.
        parked = 1'b0;
        cycle();
        check("depart_state", int'(state), 0);
        parked = 1'b1;
        cycle();
        check("grace_state", int'(state), 1);
        ticks(9);
        check("grace_after_9", int'(state), 1);
        ticks(1);
        check("grace_expire_state", int'(state), 3);
        check("grace_expire_pulse", int'(expire_pulse), 1);
        check("grace_blink0", int'(blink), 0);
        ticks(1);
        check("blink_1", int'(blink), 1);
        check("pulse_after_grace", int'(expire_pulse), 0);
        ticks(1);
        check("blink_2", int'(blink), 0);
        ticks(1);
        check("blink_3", int'(blink), 1);
        ticks(1);
        check("blink_4", int'(blink), 0);
        ticks(1);
        check("blink_5", int'(blink), 1);
        coin(2'd0);
        check("exp_coin_state", int'(state), 2);
        check("exp_coin_time", int'(time_left), 60);
        check("exp_coin_blink", int'(blink), 0);
        check("exp_coin_expired", int'(expired), 0);

        // Saturation at the display ceiling: 34 x 300 caps at 9999.
        parked = 1'b0;
        cycle();
        repeat (34) coin(2'd3);
        check("sat_idle", int'(time_left), 9999);
        parked = 1'b1;
        cycle();
        coin_in  = 1'b1;
        coin_val = 2'd3;
        sec_tick = 1'b1;
        cycle();
        coin_in  = 1'b0;
        sec_tick = 1'b0;
        check("sat_max_coin_tick", int'(time_left), 9998);

        // 9960 -> 10 ticks -> 9950, then coin3 + tick -> 9998.
        parked = 1'b0;
        cycle();
        repeat (33) coin(2'd3);
        coin(2'd0);
        check("prepay_9960", int'(time_left), 9960);
        parked = 1'b1;
        cycle();
        ticks(10);
        check("run_9950", int'(time_left), 9950);
        coin_in  = 1'b1;
        coin_val = 2'd3;
        sec_tick = 1'b1;
        cycle();
        coin_in  = 1'b0;
        sec_tick = 1'b0;
        check("sat_9950_coin_tick", int'(time_left), 9998);

        // Departure with a simultaneous coin discards the coin.
        parked = 1'b0;
        cycle();
        coin(2'd1);
        coin(2'd1);
        parked = 1'b1;
        cycle();
        ticks(40);
        check("run_200", int'(time_left), 200);
        parked   = 1'b0;
        coin_in  = 1'b1;
        coin_val = 2'd3;
        cycle();
        coin_in  = 1'b0;
        check("depart_coin_state", int'(state), 0);
        check("depart_coin_time", int'(time_left), 0);
        cycle();
        check("depart_coin_discard", int'(time_left), 0);

        // GRACE: coin and tick together -> RUN with full coin value.
        parked = 1'b1;
        cycle();
        ticks(3);
        check("grace2_state", int'(state), 1);
        coin_in  = 1'b1;
        coin_val = 2'd2;
        sec_tick = 1'b1;
        cycle();
        coin_in  = 1'b0;
        sec_tick = 1'b0;
        check("grace_coin_tick_state", int'(state), 2);
        check("grace_coin_tick_time", int'(time_left), 180);

        // Reset mid-RUN wins over tick and coin.
        rst      = 1'b1;
        coin_in  = 1'b1;
        sec_tick = 1'b1;
        cycle();
        rst      = 1'b0;
        coin_in  = 1'b0;
        sec_tick = 1'b0;
        check("rst_run_state", int'(state), 0);
        check("rst_run_time", int'(time_left), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
